// File: rtl/uart_rxd_pkg.sv
// Shared widths, packer state encoding and byte-count type for the UART receive interface.
package uart_rxd_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_e;

  typedef logic [2:0] byte_cnt_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO; full/empty come from registered pointers with a wrap bit.
module uart_byte_fifo
  import uart_rxd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [BYTE_W-1:0] i_wdata,
  output logic              o_full,
  input  logic              i_rd,
  output logic [BYTE_W-1:0] o_rdata,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_wr, do_rd;

  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign do_wr   = i_wr && !o_full;
  assign do_rd   = i_rd && !o_empty;

  assign wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

  // Read is combinational so a byte written in one cycle can be popped the next.
  assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/uart_rxd_if.sv
// Host-side UART receive path: byte FIFO, word packer with idle flush, output register, sticky overflow.
module uart_rxd_if
  import uart_rxd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rxd_fifo_wr,
  input  logic [BYTE_W-1:0] i_rxd_fifo_wdata,
  output logic              o_rxd_fifo_wfull,
  input  logic              i_rd,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic [2:0]        o_rbytes,
  output logic              o_overflow,
  input  logic              i_clr_ovf
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic              fifo_full, fifo_empty, pop;
  logic [BYTE_W-1:0] fifo_rdata;

  state_e            state_q, state_d;
  byte_cnt_t         cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [2:0]        rbytes_q, rbytes_d;
  logic              rvalid_q, rvalid_d;
  logic              ovf_q, ovf_d;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (i_rxd_fifo_wr),
    .i_wdata (i_rxd_fifo_wdata),
    .o_full  (fifo_full),
    .i_rd    (pop),
    .o_rdata (fifo_rdata),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    idle_d   = idle_q;
    rdata_d  = rdata_q;
    rbytes_d = rbytes_q;
    rvalid_d = rvalid_q;
    pop      = 1'b0;

    if (i_rd && rvalid_q) begin
      rvalid_d = 1'b0;
    end

    case (state_q)
      COLLECT: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          idle_d = '0;
          for (int l = 0; l < LANES; l++) begin
            if (cnt_q[1:0] == l[1:0]) begin
              asm_d[l*BYTE_W +: BYTE_W] = fifo_rdata;
            end
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            state_d = PENDING;
          end
        end else if (cnt_q == 3'd0 || TIMEOUT == 0) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          // Partial word flushed; lanes never written are still zero.
          state_d = PENDING;
          idle_d  = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      PENDING: begin
        if (!rvalid_q || i_rd) begin
          rdata_d  = asm_q;
          rbytes_d = cnt_q;
          rvalid_d = 1'b1;
          asm_d    = '0;
          cnt_d    = '0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (i_rxd_fifo_wr && fifo_full) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      asm_q    <= '0;
      idle_q   <= '0;
      rdata_q  <= '0;
      rbytes_q <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      idle_q   <= idle_d;
      rdata_q  <= rdata_d;
      rbytes_q <= rbytes_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_rxd_fifo_wfull = fifo_full;
  assign o_rdata          = rdata_q;
  assign o_rvalid         = rvalid_q;
  assign o_rbytes         = rbytes_q;
  assign o_overflow       = ovf_q;

endmodule

// File: tb/tb_uart_rxd_if.sv
// Scoreboard bench for uart_rxd_if: expected words queued at stimulus time, checked on each host read.
module tb_uart_rxd_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        wfull;
  logic        rd = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [2:0]  rbytes;
  logic        ovf;
  logic        clr = 1'b0;

  logic        wr0 = 1'b0;
  logic [7:0]  wdata0 = 8'h00;
  logic        wfull0;
  logic        rd0 = 1'b0;
  logic [31:0] rdata0;
  logic        rvalid0;
  logic [2:0]  rbytes0;
  logic        ovf0;
  logic        clr0 = 1'b0;

  logic        auto_rd = 1'b0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  nb;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_rxd_if #(.FIFO_DEPTH(16), .TIMEOUT(64)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rxd_fifo_wr    (wr),
    .i_rxd_fifo_wdata (wdata),
    .o_rxd_fifo_wfull (wfull),
    .i_rd             (rd),
    .o_rdata          (rdata),
    .o_rvalid         (rvalid),
    .o_rbytes         (rbytes),
    .o_overflow       (ovf),
    .i_clr_ovf        (clr)
  );

  uart_rxd_if #(.FIFO_DEPTH(16), .TIMEOUT(0)) dut0 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rxd_fifo_wr    (wr0),
    .i_rxd_fifo_wdata (wdata0),
    .o_rxd_fifo_wfull (wfull0),
    .i_rd             (rd0),
    .o_rdata          (rdata0),
    .o_rvalid         (rvalid0),
    .o_rbytes         (rbytes0),
    .o_overflow       (ovf0),
    .i_clr_ovf        (clr0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [7:0] b);
    wr = 1'b1;
    wdata = b;
    tick();
    wr = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [2:0] n);
    exp_t e;
    e.data = d;
    e.nb = n;
    exp_q.push_back(e);
  endtask

  // Host: read whenever a word is presented and auto-read is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rd = auto_rd && rvalid;
    end
  end

  // Monitor: every accepted host read is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd && rvalid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h/%0d expected no word", rdata, rbytes);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", rdata, e.data);
          chk("word_bytes", {29'b0, rbytes}, {29'b0, e.nb});
        end
      end
    end
  end

  initial begin
    logic seen;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rbytes", {29'b0, rbytes}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_wfull", {31'b0, wfull}, 32'd0);

    // Full word and its two-cycle latency after the last pop
    expect_word(32'h12345678, 3'd4);
    put(8'h78); put(8'h56); put(8'h34); put(8'h12);
    tick();
    chk("w4_valid_early", {31'b0, rvalid}, 32'd0);
    tick();
    chk("w4_valid", {31'b0, rvalid}, 32'd1);
    auto_rd = 1'b1;
    tick();
    tick();
    chk("w4_read_clears", {31'b0, rvalid}, 32'd0);
    chk("w4_consumed", 32'(exp_q.size()), 32'd0);

    // Idle flush after exactly 64 pop-less cycles
    auto_rd = 1'b0;
    tick();
    expect_word(32'h0000BBAA, 3'd2);
    put(8'hAA); put(8'hBB);
    repeat (65) tick();
    chk("to_not_yet", {31'b0, rvalid}, 32'd0);
    tick();
    chk("to_flushed", {31'b0, rvalid}, 32'd1);
    auto_rd = 1'b1;
    repeat (4) tick();
    chk("to_consumed", 32'(exp_q.size()), 32'd0);

    // Overflow: 4 bytes in output, 4 pending, 16 in FIFO, the rest dropped
    auto_rd = 1'b0;
    tick();
    for (int w = 0; w < 6; w++) begin
      logic [31:0] word;
      for (int b = 0; b < 4; b++) word[b*8 +: 8] = 8'(8'h20 + w*4 + b);
      expect_word(word, 3'd4);
    end
    for (int i = 0; i < 26; i++) put(8'(8'h20 + i));
    chk("ovf_wfull", {31'b0, wfull}, 32'd1);
    chk("ovf_set", {31'b0, ovf}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_cleared", {31'b0, ovf}, 32'd0);
    clr = 1'b1;
    wr = 1'b1;
    wdata = 8'hEE;
    tick();
    clr = 1'b0;
    wr = 1'b0;
    chk("ovf_set_wins", {31'b0, ovf}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_cleared2", {31'b0, ovf}, 32'd0);
    auto_rd = 1'b1;
    repeat (60) tick();
    chk("ovf_drained", 32'(exp_q.size()), 32'd0);
    chk("ovf_wfull_low", {31'b0, wfull}, 32'd0);

    // Back-to-back with continuous reads
    expect_word(32'h04030201, 3'd4);
    expect_word(32'h08070605, 3'd4);
    expect_word(32'h0C0B0A09, 3'd4);
    for (int i = 1; i <= 12; i++) put(8'(i));
    repeat (20) tick();
    chk("b2b_consumed", 32'(exp_q.size()), 32'd0);

    // Reset mid-word discards buffered bytes
    put(8'hE1); put(8'hE2); put(8'hE3);
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_rbytes", {29'b0, rbytes}, 32'd0);
    chk("mid_rst_ovf", {31'b0, ovf}, 32'd0);
    chk("mid_rst_wfull", {31'b0, wfull}, 32'd0);
    rst = 1'b0;
    expect_word(32'h44332211, 3'd4);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    repeat (80) tick();
    chk("post_rst_consumed", 32'(exp_q.size()), 32'd0);

    // TIMEOUT=0 build never flushes a partial word
    wr0 = 1'b1;
    wdata0 = 8'h5A;
    tick();
    wr0 = 1'b0;
    seen = 1'b0;
    repeat (1000) begin
      tick();
      if (rvalid0) seen = 1'b1;
    end
    chk("t0_no_flush", {31'b0, seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
